// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, occupancy count, synchronous flush and sticky error status.
module sync_fifo_prog #(
  parameter  int FIFO_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      afull_thresh,
  input  logic [CNT_W-1:0]      aempty_thresh,
  input  logic                  sticky_clr,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count,
  output logic                  ovf_sticky,
  output logic                  udf_sticky
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Handshake: a write is taken on any edge where wr_en && !full, a read on any
  // edge where rd_en && !empty (flush/rst discard both); wr_ack, overflow and
  // underflow report the outcome as one-cycle pulses on the following cycle.

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  ovf_sticky_q, ovf_sticky_d;
  logic                  udf_sticky_q, udf_sticky_d;

  logic full_w, empty_w;
  logic wr_acc, rd_acc;
  logic ovf_evt, udf_evt;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  assign wr_acc  = !flush && wr_en && !full_w;
  assign rd_acc  = !flush && rd_en && !empty_w;
  assign ovf_evt = !flush && wr_en && full_w;
  assign udf_evt = !flush && rd_en && empty_w;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    wr_ack_d     = wr_acc;
    overflow_d   = ovf_evt;
    underflow_d  = udf_evt;
    ovf_sticky_d = ovf_sticky_q;
    udf_sticky_d = udf_sticky_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        data_out_d = mem_q[rd_ptr_q];
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CNT_W'(1);
      end
      // A new error event outranks a clear arriving on the same edge.
      ovf_sticky_d = ovf_evt || (ovf_sticky_q && !sticky_clr);
      udf_sticky_d = udf_evt || (udf_sticky_q && !sticky_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      wr_ack_q     <= wr_ack_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  // Storage is never reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out    = data_out_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign full        = full_w;
  assign empty       = empty_w;
  assign almostfull  = (count_q >= afull_thresh);
  assign almostempty = (count_q <= aempty_thresh);
  assign count       = count_q;
  assign ovf_sticky  = ovf_sticky_q;
  assign udf_sticky  = udf_sticky_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a depth-8 and a depth-6 instance checked against
// queue-based reference models with directed and randomized steps.
module tb_sync_fifo_prog;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- depth-8 instance ----------------
  logic        rst8 = 1'b1, flush8 = 1'b0, wr8 = 1'b0, rd8 = 1'b0, clr8 = 1'b0;
  logic [15:0] din8 = '0;
  logic [3:0]  af8 = 4'd6, ae8 = 4'd2;
  logic [15:0] dout8;
  logic        ack8, ovf8, udf8, full8, empty8, afull8, aempty8, os8, us8;
  logic [3:0]  cnt8;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .flush(flush8), .data_in(din8), .wr_en(wr8),
    .rd_en(rd8), .afull_thresh(af8), .aempty_thresh(ae8), .sticky_clr(clr8),
    .data_out(dout8), .wr_ack(ack8), .overflow(ovf8), .underflow(udf8),
    .full(full8), .empty(empty8), .almostfull(afull8), .almostempty(aempty8),
    .count(cnt8), .ovf_sticky(os8), .udf_sticky(us8)
  );

  // ---------------- depth-6 instance ----------------
  logic        rst6 = 1'b1, flush6 = 1'b0, wr6 = 1'b0, rd6 = 1'b0, clr6 = 1'b0;
  logic [15:0] din6 = '0;
  logic [2:0]  af6 = 3'd5, ae6 = 3'd1;
  logic [15:0] dout6;
  logic        ack6, ovf6, udf6, full6, empty6, afull6, aempty6, os6, us6;
  logic [2:0]  cnt6;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) u_dut6 (
    .clk(clk), .rst(rst6), .flush(flush6), .data_in(din6), .wr_en(wr6),
    .rd_en(rd6), .afull_thresh(af6), .aempty_thresh(ae6), .sticky_clr(clr6),
    .data_out(dout6), .wr_ack(ack6), .overflow(ovf6), .underflow(udf6),
    .full(full6), .empty(empty6), .almostfull(afull6), .almostempty(aempty6),
    .count(cnt6), .ovf_sticky(os6), .udf_sticky(us6)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q8[$];
  logic [15:0] exp_q6[$];
  logic [15:0] e_dout8 = '0, e_dout6 = '0;
  logic        e_ack8 = 0, e_ovf8 = 0, e_udf8 = 0, e_os8 = 0, e_us8 = 0;
  logic        e_ack6 = 0, e_ovf6 = 0, e_udf6 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver + model, depth 8 ----------------
  task automatic step8(input logic r, input logic f, input logic w, input logic rd,
                       input logic [15:0] d, input logic c);
    logic was_full, was_empty;
    int   n;
    rst8 = r; flush8 = f; wr8 = w; rd8 = rd; din8 = d; clr8 = c;
    n         = exp_q8.size();
    was_full  = (n == 8);
    was_empty = (n == 0);
    if (r) begin
      exp_q8.delete();
      e_dout8 = '0; e_ack8 = 0; e_ovf8 = 0; e_udf8 = 0; e_os8 = 0; e_us8 = 0;
    end else if (f) begin
      exp_q8.delete();
      e_ack8 = 0; e_ovf8 = 0; e_udf8 = 0;
    end else begin
      e_ack8 = w && !was_full;
      e_ovf8 = w && was_full;
      e_udf8 = rd && was_empty;
      if (rd && !was_empty) e_dout8 = exp_q8.pop_front();
      if (e_ack8) exp_q8.push_back(d);
      e_os8 = e_ovf8 || (e_os8 && !c);
      e_us8 = e_udf8 || (e_us8 && !c);
    end
    @(posedge clk);
    #1;
    rst8 = 0; flush8 = 0; wr8 = 0; rd8 = 0; clr8 = 0;
    n = exp_q8.size();
    check("d8_data_out",   32'(dout8),   32'(e_dout8));
    check("d8_wr_ack",     32'(ack8),    32'(e_ack8));
    check("d8_overflow",   32'(ovf8),    32'(e_ovf8));
    check("d8_underflow",  32'(udf8),    32'(e_udf8));
    check("d8_count",      32'(cnt8),    32'(n));
    check("d8_full",       32'(full8),   32'(n == 8));
    check("d8_empty",      32'(empty8),  32'(n == 0));
    check("d8_almostfull", 32'(afull8),  32'(n >= int'(af8)));
    check("d8_almostempty",32'(aempty8), 32'(n <= int'(ae8)));
    check("d8_ovf_sticky", 32'(os8),     32'(e_os8));
    check("d8_udf_sticky", 32'(us8),     32'(e_us8));
  endtask

  // ---------------- driver + model, depth 6 ----------------
  task automatic step6(input logic r, input logic w, input logic rd, input logic [15:0] d);
    logic was_full, was_empty;
    int   n;
    rst6 = r; wr6 = w; rd6 = rd; din6 = d;
    n         = exp_q6.size();
    was_full  = (n == 6);
    was_empty = (n == 0);
    if (r) begin
      exp_q6.delete();
      e_dout6 = '0; e_ack6 = 0; e_ovf6 = 0; e_udf6 = 0;
    end else begin
      e_ack6 = w && !was_full;
      e_ovf6 = w && was_full;
      e_udf6 = rd && was_empty;
      if (rd && !was_empty) e_dout6 = exp_q6.pop_front();
      if (e_ack6) exp_q6.push_back(d);
    end
    @(posedge clk);
    #1;
    rst6 = 0; wr6 = 0; rd6 = 0;
    n = exp_q6.size();
    check("d6_data_out",  32'(dout6),  32'(e_dout6));
    check("d6_wr_ack",    32'(ack6),   32'(e_ack6));
    check("d6_overflow",  32'(ovf6),   32'(e_ovf6));
    check("d6_underflow", 32'(udf6),   32'(e_udf6));
    check("d6_count",     32'(cnt6),   32'(n));
    check("d6_full",      32'(full6),  32'(n == 6));
    check("d6_empty",     32'(empty6), 32'(n == 0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] rv;
    #1;
    // reset state
    step8(1, 0, 0, 0, 16'h0, 0);
    step6(1, 0, 0, 16'h0);

    // fill to full, then one overflowing write
    for (int i = 1; i <= 8; i++) step8(0, 0, 1, 0, 16'(i), 0);
    step8(0, 0, 1, 0, 16'h0009, 0);

    // drain in order, then one underflowing read
    for (int i = 0; i < 8; i++) step8(0, 0, 0, 1, 16'h0, 0);
    step8(0, 0, 0, 1, 16'h0, 0);

    // simultaneous read/write at count 4
    for (int i = 0; i < 4; i++) step8(0, 0, 1, 0, 16'h0010 + 16'(i), 0);
    step8(0, 0, 1, 1, 16'h0014, 0);
    // simultaneous at full
    for (int i = 0; i < 4; i++) step8(0, 0, 1, 0, 16'h0020 + 16'(i), 0);
    step8(0, 0, 1, 1, 16'h0030, 0);
    // drain to empty, then simultaneous at empty
    for (int i = 0; i < 7; i++) step8(0, 0, 0, 1, 16'h0, 0);
    step8(0, 0, 1, 1, 16'h0040, 0);
    step8(0, 0, 0, 1, 16'h0, 0);

    // flush at count 5 with a concurrent write
    for (int i = 0; i < 5; i++) step8(0, 0, 1, 0, 16'h0050 + 16'(i), 0);
    step8(0, 1, 1, 0, 16'h0055, 0);

    // sticky clear racing a new overflow, then clear alone
    for (int i = 0; i < 8; i++) step8(0, 0, 1, 0, 16'h0060 + 16'(i), 0);
    step8(0, 0, 1, 0, 16'h0068, 1);
    step8(0, 0, 0, 0, 16'h0, 1);

    // reset mid-burst at count 3, then first write reads back
    step8(0, 1, 0, 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) step8(0, 0, 1, 0, 16'h0070 + 16'(i), 0);
    step8(1, 0, 1, 1, 16'h0073, 0);
    step8(0, 0, 1, 0, 16'hBEEF, 0);
    step8(0, 0, 0, 1, 16'h0, 0);
    step8(0, 0, 0, 0, 16'h0, 0);

    // threshold extremes: stuck-at-1 and stuck-at-0 almostfull
    af8 = 4'd0; ae8 = 4'd9;
    step8(0, 0, 1, 0, 16'h1234, 0);
    af8 = 4'd9; ae8 = 4'd0;
    step8(0, 0, 0, 0, 16'h0, 0);
    af8 = 4'd6; ae8 = 4'd2;

    // depth 6: full/empty sweeps forcing pointer wrap, then random pairs
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) step6(0, 1, 0, 16'($urandom));
      step6(0, 1, 0, 16'hDEAD);
      for (int i = 0; i < 6; i++) step6(0, 0, 1, 16'h0);
      step6(0, 0, 1, 16'h0);
    end
    for (int i = 0; i < 20; i++) begin
      rv = 16'($urandom);
      step6(0, 1, 0, rv);
      step6(0, $urandom_range(0, 1) == 1, 1, 16'($urandom));
    end

    // depth 8: randomized traffic with occasional flush/reset/clear
    for (int i = 0; i < 400; i++) begin
      af8 = 4'($urandom_range(0, 9));
      ae8 = 4'($urandom_range(0, 9));
      step8($urandom_range(0, 99) == 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 50,
            16'($urandom),
            $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
